// File: rtl/mem_pkg.sv
// Shared encodings for the data memory unit: access sizes, FSM states and
// the byte count of each access size.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Size code 2'b11 is treated as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_ram.sv
// One byte lane of the data memory: synchronous write with enable and a
// registered read. Contents start at zero and are never touched by reset.
module mem_lane_ram #(
    parameter int WORDS   = 2048,
    parameter int WORD_AW = 11
) (
    input  logic               clk,
    input  logic               we,
    input  logic [WORD_AW-1:0] addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata
);

    logic [7:0] mem [WORDS] = '{default: 8'h00};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_unit.sv
// Handshaked byte-addressable data memory over four byte-lane RAMs.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of splitting them.
module data_mem_unit
    import mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 8192,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int WW = AW - 2;
    localparam int LW = ADDR_W + 1;

    state_t          state;
    logic [AW-1:0]   addr_q;
    logic [2:0]      nbytes_q;
    logic [31:0]     wdata_q;
    logic            write_q;
    logic            unsigned_q;
    logic            err_q;

    logic [3:0][7:0] lane_rdata;
    logic [3:0][7:0] hold_q;
    logic [3:0]      lane_we;
    logic [WW-1:0]   lane_addr;
    logic [31:0]     wdata_rot;
    logic [31:0]     merged;
    logic [31:0]     raw;
    logic [31:0]     load_val;

    function automatic logic [31:0] extend_load(input logic [31:0] r, input logic [2:0] nb,
                                                input logic uns);
        case (nb)
            3'd1:    return {{24{~uns & r[7]}}, r[7:0]};
            3'd2:    return {{16{~uns & r[15]}}, r[15:0]};
            default: return r;
        endcase
    endfunction

    // The last addressed byte decides range, so halves/words near the top are caught.
    logic [2:0]    req_nbytes;
    logic [LW-1:0] req_last;
    logic          req_oor;
    logic          req_misal;
    logic          req_err;

    assign req_nbytes = size_bytes(req_size);
    assign req_last   = {1'b0, req_addr} + LW'(req_nbytes - 3'd1);
    assign req_oor    = req_last >= LW'(DEPTH_BYTES);
`ifdef MEM_MISALIGN_TRAP_EN
    assign req_misal  = ((req_nbytes == 3'd2) && req_addr[0]) ||
                        ((req_nbytes == 3'd4) && (req_addr[1:0] != 2'b00));
`else
    assign req_misal  = 1'b0;
`endif
    assign req_err    = req_oor || req_misal;
    assign req_ready  = (state == ST_IDLE);

    logic [1:0] off;
    logic [2:0] last_pos;
    logic       split;

    assign off      = addr_q[1:0];
    assign last_pos = {1'b0, off} + nbytes_q - 3'd1;
    assign split    = last_pos[2];

    // Beat 0 covers lanes off..last_pos of the base word; beat 1 covers the overflow lanes.
    always_comb begin
        lane_addr = addr_q[AW-1:2];
        lane_we   = '0;
        if (state == ST_BEAT1) begin
            lane_addr = addr_q[AW-1:2] + WW'(1);
        end
        for (int l = 0; l < 4; l++) begin
            if (state == ST_BEAT0) begin
                lane_we[l] = write_q && (3'(l) >= {1'b0, off}) && (3'(l) <= last_pos);
            end else if (state == ST_BEAT1) begin
                lane_we[l] = write_q && (2'(l) <= last_pos[1:0]);
            end
        end
    end

    always_comb begin
        case (off)
            2'd0:    wdata_rot = wdata_q;
            2'd1:    wdata_rot = {wdata_q[23:0], wdata_q[31:24]};
            2'd2:    wdata_rot = {wdata_q[15:0], wdata_q[31:16]};
            default: wdata_rot = {wdata_q[7:0],  wdata_q[31:8]};
        endcase
    end

    // Split loads: upper lanes came from beat 0 (held), lower lanes from beat 1.
    always_comb begin
        merged = lane_rdata;
        for (int l = 0; l < 4; l++) begin
            if (split && (2'(l) >= off)) begin
                merged[8*l +: 8] = hold_q[l];
            end
        end
        case (off)
            2'd0:    raw = merged;
            2'd1:    raw = {merged[7:0],  merged[31:8]};
            2'd2:    raw = {merged[15:0], merged[31:16]};
            default: raw = {merged[23:0], merged[31:24]};
        endcase
        load_val = extend_load(raw, nbytes_q, unsigned_q);
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        mem_lane_ram #(
            .WORDS  (DEPTH_BYTES / 4),
            .WORD_AW(WW)
        ) u_ram (
            .clk  (clk),
            .we   (lane_we[l]),
            .addr (lane_addr),
            .wdata(wdata_rot[8*l +: 8]),
            .rdata(lane_rdata[l])
        );
    end

    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            addr_q     <= req_addr[AW-1:0];
            nbytes_q   <= req_nbytes;
            wdata_q    <= req_wdata;
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            err_q      <= req_err;
        end
        if (state == ST_BEAT1) begin
            hold_q <= lane_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state <= req_err ? ST_RESP : ST_BEAT0;
                    end
                end
                ST_BEAT0: state <= split ? ST_BEAT1 : ST_RESP;
                ST_BEAT1: state <= ST_RESP;
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_rdata <= (err_q || write_q) ? 32'h0 : load_val;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: byte-array reference model plus per-cycle response
// and ready checks, with literal expectations from the directed vectors.
`timescale 1ns/1ps
module tb_data_mem_unit;

    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    data_mem_unit #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem_m [DEPTH];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    int          last_lat = 0;
    bit          skip_ready = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    // Reference behaviour: plain byte array, little-endian, latency from access shape.
    function automatic exp_t model_accept(input logic w, input logic [31:0] a, input logic [31:0] d,
                                          input logic [1:0] sz, input logic u, input int acc);
        exp_t        e;
        int          nb;
        longint      last;
        bit          err;
        logic [31:0] v;
        nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        last = longint'(a) + nb - 1;
        err  = (last >= DEPTH);
`ifdef MEM_MISALIGN_TRAP_EN
        if ((a % nb) != 0) err = 1'b1;
`endif
        v = '0;
        if (!err) begin
            for (int k = 0; k < nb; k++) begin
                if (w) mem_m[int'(a) + k] = d[8*k +: 8];
                else   v[8*k +: 8] = mem_m[int'(a) + k];
            end
            if (!w && !u && nb < 4 && v[8*nb-1]) begin
                for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
            end
        end
        e.rdata = (err || w) ? 32'h0 : v;
        e.err   = err;
        e.acc   = acc;
        e.due   = acc + (err ? 1 : (((a % 4) + nb > 4) ? 3 : 2));
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   busy;
        if (mon_en) begin
            busy = (exp_q.size() > 0) && (cyc >= exp_q[0].acc) && (cyc < exp_q[0].due);
            if (!skip_ready) chk("req_ready", req_ready, !busy);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                    chk("latency", cyc - e.acc, e.due - e.acc);
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                    last_lat   = cyc - e.acc;
                end
            end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
                chk("missing_rsp", rsp_valid, 1);
                exp_q.delete(0);
            end
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u, input bit keep);
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a;
        req_wdata = d; req_size = sz; req_unsigned = u;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
        end else begin
            exp_q.push_back(model_accept(w, a, d, sz, u, cyc + 1));
            @(posedge clk);
            #1;
            if (!keep) req_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        #1;
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u);
        send(w, a, d, sz, u, 1'b0);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        xfer(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
        chk("st10_lat", last_lat, 2);
        xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        chk("ld10_word", last_rdata, 32'hDEADBEEF);
        chk("ld10_err", last_err, 0);
        chk("ld10_lat", last_lat, 2);
        xfer(1'b0, 32'h10, 32'h0, 2'b00, 1'b0);
        chk("ld10_byte_s", last_rdata, 32'hFFFFFFEF);
        xfer(1'b0, 32'h10, 32'h0, 2'b00, 1'b1);
        chk("ld10_byte_u", last_rdata, 32'h000000EF);
        xfer(1'b0, 32'h12, 32'h0, 2'b01, 1'b1);
        chk("ld12_half_u", last_rdata, 32'h0000DEAD);
        xfer(1'b0, 32'h12, 32'h0, 2'b01, 1'b0);
        chk("ld12_half_s", last_rdata, 32'hFFFFDEAD);
        xfer(1'b0, 32'h13, 32'h0, 2'b11, 1'b0);

        xfer(1'b1, 32'h1E, 32'h11223344, 2'b10, 1'b0);
        xfer(1'b0, 32'h1E, 32'h0, 2'b10, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("ld1e_err", last_err, 1);
        chk("ld1e_lat", last_lat, 1);
        xfer(1'b0, 32'h20, 32'h0, 2'b00, 1'b1);
        chk("ld20_byte", last_rdata, 32'h00);
        xfer(1'b0, 32'h21, 32'h0, 2'b00, 1'b1);
        chk("ld21_byte", last_rdata, 32'h00);
`else
        chk("ld1e_word", last_rdata, 32'h11223344);
        chk("ld1e_lat", last_lat, 3);
        xfer(1'b0, 32'h20, 32'h0, 2'b00, 1'b1);
        chk("ld20_byte", last_rdata, 32'h22);
        xfer(1'b0, 32'h21, 32'h0, 2'b00, 1'b1);
        chk("ld21_byte", last_rdata, 32'h11);
`endif

        xfer(1'b0, DEPTH - 2, 32'h0, 2'b10, 1'b0);
        chk("oor_word_err", last_err, 1);
        chk("oor_word_rdata", last_rdata, 32'h0);
        chk("oor_word_lat", last_lat, 1);
        xfer(1'b1, DEPTH, 32'h000000AA, 2'b00, 1'b0);
        chk("oor_byte_err", last_err, 1);
        xfer(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        chk("ld0_unchanged", last_rdata, 32'h0);
        xfer(1'b0, DEPTH - 1, 32'h0, 2'b00, 1'b0);
        chk("top_byte_ok", last_err, 0);

        send(1'b1, 32'h40, 32'h0000005A, 2'b00, 1'b0, 1'b1);
        send(1'b1, 32'h43, 32'h0000BEEF, 2'b01, 1'b0, 1'b1);
        send(1'b0, 32'h40, 32'h0, 2'b10, 1'b1, 1'b1);
        send(1'b0, 32'h42, 32'h0, 2'b01, 1'b1, 1'b1);
        send(1'b0, 32'h44, 32'h0, 2'b00, 1'b0, 1'b0);
        wait_done();
`ifdef MEM_MISALIGN_TRAP_EN
        chk("b2b_ld44", last_rdata, 32'h00000000);
`else
        chk("b2b_ld44", last_rdata, 32'hFFFFFFBE);
`endif

        skip_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h5E;
        req_wdata = 32'hA1B2C3D4; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0;
        @(negedge clk);
`ifndef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        mem_m[32'h5E] = 8'hD4;
        mem_m[32'h5F] = 8'hC3;
`endif
        reset = 1'b0;
        #1;
        chk("mid_reset_rsp_valid", rsp_valid, 0);
        chk("mid_reset_req_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_req_ready", req_ready, 1);
        skip_ready = 1'b0;

        xfer(1'b0, 32'h5E, 32'h0, 2'b00, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("rst_ld5e", last_rdata, 32'h00);
`else
        chk("rst_ld5e", last_rdata, 32'hD4);
`endif
        xfer(1'b0, 32'h5F, 32'h0, 2'b00, 1'b1);
        xfer(1'b0, 32'h60, 32'h0, 2'b00, 1'b1);
        chk("rst_ld60", last_rdata, 32'h00);
        xfer(1'b0, 32'h61, 32'h0, 2'b00, 1'b1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
